// File: rtl/jump_redirect_ctrl_pkg.sv
// Shared definitions for the jump redirect controller.
// Contents:
//   TAG_W / TAG_INVALID / DATA_W / DEPTH  - widths, reserved tag, buffer size
//   IDX_W / CNT_W                         - derived index and occupancy widths
//   pend_entry_t                          - one pending resolved jump
//   redir_state_t                         - redirect sequencer states
package jump_redirect_ctrl_pkg;

    localparam int               TAG_W       = 4;
    localparam logic [TAG_W-1:0] TAG_INVALID = '1;
    localparam int               DATA_W      = 32;
    localparam int               DEPTH       = 4;
    localparam int               IDX_W       = $clog2(DEPTH);
    localparam int               CNT_W       = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] next_pc;
        logic [DATA_W-1:0] ori_pc;
    } pend_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        REDIR,
        FLUSH
    } redir_state_t;

endpackage

// File: rtl/jump_pending_buf.sv
// Pending-jump buffer: DEPTH slots holding (tag, next_pc) of resolved jumps
// waiting for their commit.
// Ports:
//   clk, rst                      - clock, async active-high reset
//   alloc, alloc_tag, alloc_next_pc - write into the lowest-index free slot
//                                   (ignored when full)
//   lookup_tag                    - CAM search key
//   hit, hit_idx, hit_next_pc     - lowest-index valid slot matching lookup_tag
//   free, free_idx                - invalidate one slot
//   flush_all                     - invalidate every slot (wins over alloc)
//   count, full                   - occupancy of the registered valid bits
module jump_pending_buf
    import jump_redirect_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc,
    input  logic [TAG_W-1:0]  alloc_tag,
    input  logic [DATA_W-1:0] alloc_next_pc,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic              hit,
    output logic [IDX_W-1:0]  hit_idx,
    output logic [DATA_W-1:0] hit_next_pc,
    input  logic              free,
    input  logic [IDX_W-1:0]  free_idx,
    input  logic              flush_all,
    output logic [CNT_W-1:0]  count,
    output logic              full
);

    logic [DEPTH-1:0]  valid;
    logic [TAG_W-1:0]  tag_q     [DEPTH];
    logic [DATA_W-1:0] next_pc_q [DEPTH];

    logic              free_found;
    logic [IDX_W-1:0]  alloc_idx;
    logic              do_alloc;

    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise the tool infers a latch to hold the old value.
    always_comb begin
        free_found  = 1'b0;
        alloc_idx   = '0;
        hit         = 1'b0;
        hit_idx     = '0;
        hit_next_pc = '0;
        count       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CNT_W'(valid[i]);
            if (!valid[i] && !free_found) begin
                free_found = 1'b1;
                alloc_idx  = IDX_W'(i);
            end
            if (valid[i] && !hit && (tag_q[i] == lookup_tag)) begin
                hit         = 1'b1;
                hit_idx     = IDX_W'(i);
                hit_next_pc = next_pc_q[i];
            end
        end
    end

    assign full     = (count == CNT_W'(DEPTH));
    assign do_alloc = alloc && !full && !flush_all;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (flush_all) begin
            valid <= '0;
        end else begin
            // free_idx always names a valid slot and alloc_idx a free one,
            // so the two writes never collide.
            if (free)     valid[free_idx]  <= 1'b0;
            if (do_alloc) valid[alloc_idx] <= 1'b1;
        end
    end

    // NOTE: payload storage has no reset; the valid bits alone decide whether
    // a slot means anything, so resetting the data would only cost flops.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            tag_q[alloc_idx]     <= alloc_tag;
            next_pc_q[alloc_idx] <= alloc_next_pc;
        end
    end

endmodule

// File: rtl/jump_redirect_ctrl.sv
// Jump redirect controller: buffers resolved jumps, writes the link value
// back to the ROB, and once the ROB commits a jump issues a fetch redirect
// handshake followed by a one-cycle pipeline flush.
// Ports:
//   clk, rst                              - clock, async active-high reset
//   jmp_target/jmp_next_pc/jmp_ori_pc     - resolved jump (TAG_INVALID = none)
//   commit_valid/commit_tag               - ROB commit port
//   redirect_ready                        - fetch accepts the redirect
//   jmp_stall                             - buffer full, jump unit holds
//   commit_stall                          - redirect/flush in progress
//   wb_valid/wb_tag/wb_val                - link writeback (ori_pc)
//   redirect_valid/redirect_pc            - redirect request to fetch
//   flush                                 - one-cycle flush pulse
module jump_redirect_ctrl
    import jump_redirect_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [TAG_W-1:0]  jmp_target,
    input  logic [DATA_W-1:0] jmp_next_pc,
    input  logic [DATA_W-1:0] jmp_ori_pc,
    input  logic              commit_valid,
    input  logic [TAG_W-1:0]  commit_tag,
    input  logic              redirect_ready,
    output logic              jmp_stall,
    output logic              commit_stall,
    output logic              wb_valid,
    output logic [TAG_W-1:0]  wb_tag,
    output logic [DATA_W-1:0] wb_val,
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              flush
);

    redir_state_t      state_q, state_d;
    logic [DATA_W-1:0] redirect_pc_q;

    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [DATA_W-1:0] hit_next_pc;
    logic [CNT_W-1:0]  count;
    logic              full;

    logic              capture_ok;
    logic              bypass;
    logic              take_redirect;
    pend_entry_t       new_entry;

    // Jumps arriving during the flush cycle are wrong-path and are dropped,
    // as are jumps presented while the buffer is full.
    assign capture_ok    = (jmp_target != TAG_INVALID) && (state_q != FLUSH) && !full;
    assign bypass        = capture_ok && commit_valid && (commit_tag == jmp_target);
    assign take_redirect = (state_q == IDLE) && commit_valid && (hit || bypass);

    // A bypassed jump is consumed in the cycle it arrives, so it never takes a slot.
    always_comb begin
        new_entry.valid   = capture_ok && !(take_redirect && !hit);
        new_entry.tag     = jmp_target;
        new_entry.next_pc = jmp_next_pc;
        new_entry.ori_pc  = jmp_ori_pc;
    end

    jump_pending_buf u_buf (
        .clk           (clk),
        .rst           (rst),
        .alloc         (new_entry.valid),
        .alloc_tag     (new_entry.tag),
        .alloc_next_pc (new_entry.next_pc),
        .lookup_tag    (commit_tag),
        .hit           (hit),
        .hit_idx       (hit_idx),
        .hit_next_pc   (hit_next_pc),
        .free          ((state_q == IDLE) && commit_valid && hit),
        .free_idx      (hit_idx),
        .flush_all     (state_q == FLUSH),
        .count         (count),
        .full          (full)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (take_redirect)  state_d = REDIR;
            REDIR:   if (redirect_ready) state_d = FLUSH;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            redirect_pc_q <= '0;
            wb_valid      <= 1'b0;
            wb_tag        <= TAG_INVALID;
            wb_val        <= '0;
        end else begin
            state_q <= state_d;
            if (take_redirect)
                redirect_pc_q <= hit ? hit_next_pc : jmp_next_pc;
            wb_valid <= capture_ok;
            wb_tag   <= capture_ok ? jmp_target : TAG_INVALID;
            wb_val   <= capture_ok ? new_entry.ori_pc : '0;
        end
    end

    assign jmp_stall      = (count == CNT_W'(DEPTH));
    assign commit_stall   = (state_q != IDLE);
    assign redirect_valid = (state_q == REDIR);
    assign redirect_pc    = redirect_pc_q;
    assign flush          = (state_q == FLUSH);

endmodule

// File: doc/jump_redirect_ctrl.md
Name: jump_redirect_ctrl

Overview:
- Sequences the PC redirect produced by the jump unit.
- Captures each resolved jump (tag, next_pc, ori_pc) into a small pending buffer and writes the link value ori_pc back to the ROB.
- Holds the redirect until the ROB commits that jump's tag, then drives a fetch redirect handshake followed by a one-cycle pipeline flush.
- Sits between the jump unit outputs, the ROB commit port and the fetch stage.

Parameters:
- TAG_W, 4, width of instruction tag (matches INST_TAG_WIDTH)
- TAG_INVALID, {TAG_W{1'b1}}, reserved "no instruction" tag
- DATA_W, 32, PC/data width (matches COMMON_WIDTH)
- DEPTH, 4, pending-jump buffer entries

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- jmp_target  input  TAG_W  tag of resolved jump; TAG_INVALID = no jump this cycle
- jmp_next_pc  input  DATA_W  jump destination
- jmp_ori_pc  input  DATA_W  return address (pc+4)
- commit_valid  input  1  ROB commits an instruction this cycle
- commit_tag  input  TAG_W  tag being committed
- redirect_ready  input  1  fetch accepts redirect
- jmp_stall  output  1  buffer full; jump unit must hold
- commit_stall  output  1  ROB must not commit (redirect/flush in progress)
- wb_valid  output  1  link writeback valid
- wb_tag  output  TAG_W  writeback tag
- wb_val  output  DATA_W  writeback value (= ori_pc)
- redirect_valid  output  1  redirect request to fetch
- redirect_pc  output  DATA_W  new fetch PC
- flush  output  1  one-cycle pipeline flush pulse

Behaviour:
- Reset (async, any time incl. mid-redirect):
  - all entries invalid, state IDLE
  - wb_valid=0, wb_tag=TAG_INVALID, wb_val=0
  - redirect_valid=0, redirect_pc=0, flush=0
  - jmp_stall=0, commit_stall=0
- Capture: at posedge, if jmp_target!=TAG_INVALID and state!=FLUSH, write (tag, next_pc, ori_pc) into the lowest-index free entry.
- Writeback: registered, 1-cycle latency. The cycle after capture, wb_valid=1, wb_tag=captured tag, wb_val=ori_pc; otherwise wb_valid=0 and wb_tag=TAG_INVALID.
- Full rules:
  - jmp_stall=1 (combinational) when count==DEPTH.
  - Presenting a jump while jmp_stall=1 is a protocol violation (bench assertion); the jump is dropped and no writeback occurs.
  - An entry freed this cycle does not clear jmp_stall until the next cycle.
- Duplicate valid tag on capture: protocol violation, assertion only.
- FSM states:
  - IDLE
    - If commit_valid and commit_tag matches a valid entry, or matches jmp_target captured in the same cycle (bypass): load redirect_pc=next_pc, free that entry, go REDIR.
    - A non-matching commit is ignored.
  - REDIR
    - redirect_valid=1, redirect_pc stable.
    - On redirect_ready=1 at posedge: go FLUSH (redirect_valid falls next cycle).
    - Waits indefinitely while redirect_ready=0.
  - FLUSH
    - flush=1 for exactly one cycle.
    - All entries invalidated; capture suppressed this cycle (wrong-path).
    - Next state IDLE.
- commit_stall=1 in REDIR and FLUSH; commits presented there are ignored (assertion).
- The redirect register is a single slot; at most one redirect is outstanding.
- No arithmetic is performed; PC values pass through unmodified, full DATA_W.

Decomposition:
- Shared package: TAG_W / TAG_INVALID / DATA_W constants, the pending-entry typedef (valid, tag, next_pc, ori_pc), and the FSM state enum (IDLE, REDIR, FLUSH).
- One sub-module: jump_pending_buf, holding the DEPTH-entry buffer with:
  - lowest-free allocation
  - tag CAM lookup
  - free-by-index
  - flush-all
  - count/full outputs
- The FSM and writeback register live in the top module.

Test Plan:
- Reset mid-REDIR: assert rst while redirect_valid=1 -> same cycle, redirect_valid=0, flush=0, commit_stall=0; later commit of the old tag -> no redirect.
- Single jump: jmp_target=3, next_pc=0x100, ori_pc=0x84 -> next cycle wb_valid=1, wb_tag=3, wb_val=0x84. Commit tag 3 with redirect_ready=1 -> redirect_valid=1, redirect_pc=0x100 for one cycle, then flush=1 for one cycle, then IDLE.
- Backpressure: hold redirect_ready=0 for 5 cycles -> redirect_valid and redirect_pc=0x100 stable, commit_stall=1. Release -> flush the cycle after acceptance.
- Full: capture tags 1,2,3,4 -> jmp_stall=1; tag 5 presented -> dropped, no wb. Commit 2 -> after redirect+flush, buffer empty and jmp_stall=0.
- Bypass: jmp_target=6 and commit_tag=6 in the same cycle -> wb for tag 6 next cycle and redirect to its next_pc.
- Flush kills capture: jump tag 7 arrives in the FLUSH cycle -> no wb_valid; a later commit of 7 -> no redirect.
